// File: rtl/lfsr_prbs.sv
// lfsr_prbs: Fibonacci PRBS generator plus self-synchronising PRBS checker.
// The generator emits the MSB of its LFSR; the checker shifts received bits
// into its own LFSR image and predicts each incoming bit from the taps.
// After WIDTH samples the checker is locked. Mismatches are flagged,
// counted in a saturating counter and tracked per window for loss of lock.

module lfsr_prbs #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [63:0] TAPS     = 64'h0000_0000_8020_0003,
  parameter logic [63:0] SEED     = 64'h0000_0000_0000_0001,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WIN      = 256,
  parameter int unsigned LOSS_THR = 8
) (
  input  logic             Clk,
  input  logic             ARst,
  input  logic             Enable,
  input  logic             InjErr,
  output logic             GenOut,
  input  logic             ChkIn,
  input  logic             ClrCnt,
  output logic             Locked,
  output logic             ErrPulse,
  output logic [CNT_W-1:0] ErrCnt
);

  // Counter widths sized to hold their terminal values.
  localparam int unsigned SYNC_W = $clog2(WIDTH + 1);
  localparam int unsigned WIN_W  = $clog2(WIN);
  localparam int unsigned WERR_W = $clog2(LOSS_THR + 1);

  localparam logic [WIDTH-1:0]  TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0]  SEED_VAL  = SEED[WIDTH-1:0];
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(WIDTH - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(LOSS_THR - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Feedback / prediction bit: parity of the tapped state bits.
  function automatic logic tap_parity(input logic [WIDTH-1:0] v);
    return ^(v & TAP_MASK);
  endfunction

  // Generator state
  logic [WIDTH-1:0]  gen_q, gen_d;
  logic              inj_q, inj_d;

  // Checker state
  logic [WIDTH-1:0]  chk_q, chk_d;
  state_t            state_q, state_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WERR_W-1:0] werr_q, werr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic              locked_q, locked_d;

  logic              pred_s;
  logic              err_s;
  logic              cnt_inc_s;

  // Generator next state: shift in feedback, recover from the all-zero lockup.
  always_comb begin
    gen_d = gen_q;
    if (Enable) begin
      if (gen_q == '0) begin
        gen_d = SEED_VAL;
      end else begin
        gen_d = {gen_q[WIDTH-2:0], tap_parity(gen_q)};
      end
    end else begin
      gen_d = gen_q;
    end
  end

  // Injection arm: set by a request, dropped after one emitted bit has gone out.
  always_comb begin
    inj_d = inj_q;
    if (inj_q) begin
      if (Enable) begin
        inj_d = 1'b0;
      end else begin
        inj_d = 1'b1;
      end
    end else begin
      inj_d = InjErr;
    end
  end

  // Checker prediction from the received-bit history.
  always_comb begin
    pred_s = tap_parity(chk_q);
    err_s  = (ChkIn != pred_s);
  end

  // Checker history, lock FSM, window tracking and error pulse.
  always_comb begin
    chk_d     = chk_q;
    state_d   = state_q;
    sync_d    = sync_q;
    win_d     = win_q;
    werr_d    = werr_q;
    pulse_d   = 1'b0;
    cnt_inc_s = 1'b0;
    if (Enable) begin
      chk_d = {chk_q[WIDTH-2:0], ChkIn};
      case (state_q)
        ST_SYNC: begin
          if (sync_q == SYNC_LAST) begin
            state_d = ST_LOCKED;
            sync_d  = '0;
          end else begin
            sync_d  = sync_q + SYNC_W'(1);
          end
        end
        ST_LOCKED: begin
          if (err_s) begin
            pulse_d   = 1'b1;
            cnt_inc_s = 1'b1;
          end else begin
            pulse_d   = 1'b0;
            cnt_inc_s = 1'b0;
          end
          if (err_s && (werr_q == WERR_LAST)) begin
            // Too many errors in this window: drop lock and resynchronise.
            state_d = ST_SYNC;
            sync_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
            if (err_s) begin
              werr_d = werr_q + WERR_W'(1);
            end else begin
              werr_d = werr_q;
            end
          end
        end
        default: begin
          state_d = ST_SYNC;
          sync_d  = '0;
          win_d   = '0;
          werr_d  = '0;
        end
      endcase
    end else begin
      chk_d = chk_q;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // Saturating error counter; a clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ClrCnt) begin
      cnt_d = '0;
    end else if (cnt_inc_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Generator registers.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      gen_q <= SEED_VAL;
      inj_q <= 1'b0;
    end else begin
      gen_q <= gen_d;
      inj_q <= inj_d;
    end
  end

  // Checker, FSM and counter registers.
  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      chk_q    <= '0;
      state_q  <= ST_SYNC;
      sync_q   <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      chk_q    <= chk_d;
      state_q  <= state_d;
      sync_q   <= sync_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  // The injected inversion is applied on the way out only, leaving gen_q intact.
  assign GenOut   = gen_q[WIDTH-1] ^ inj_q;
  assign Locked   = locked_q;
  assign ErrPulse = pulse_q;
  assign ErrCnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Bench for lfsr_prbs: a sequence-level reference model (PRBS recurrence over
// the emitted bit stream, queue of received bits) tracks the default instance
// cycle by cycle; a second instance with a small counter checks saturation.

module tb_lfsr_prbs;

  localparam int          W     = 32;
  localparam logic [31:0] TAPS  = 32'h8020_0003;
  localparam logic [31:0] SEED  = 32'h0000_0001;
  localparam int          LOSS  = 8;
  localparam int          WINL  = 256;
  localparam int          NSEQ  = 30000;

  logic        Clk;
  logic        ARst;
  logic        Enable, InjErr, ChkIn, ClrCnt;
  logic        GenOut, Locked, ErrPulse;
  logic [15:0] ErrCnt;

  logic        s_en, s_chk, s_clr, s_inj;
  logic        s_gen, s_locked, s_pulse;
  logic [3:0]  s_cnt;

  lfsr_prbs u_dut (
    .Clk(Clk), .ARst(ARst), .Enable(Enable), .InjErr(InjErr), .GenOut(GenOut),
    .ChkIn(ChkIn), .ClrCnt(ClrCnt), .Locked(Locked), .ErrPulse(ErrPulse), .ErrCnt(ErrCnt)
  );

  lfsr_prbs #(.CNT_W(4), .LOSS_THR(1000)) u_sat (
    .Clk(Clk), .ARst(ARst), .Enable(s_en), .InjErr(s_inj), .GenOut(s_gen),
    .ChkIn(s_chk), .ClrCnt(s_clr), .Locked(s_locked), .ErrPulse(s_pulse), .ErrCnt(s_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model state
  logic seq [NSEQ];
  int   m_gidx;
  logic m_arm;
  logic rxq [$];
  logic srx [$];
  logic m_locked;
  int   m_sync, m_win, m_werr, m_cnt;
  logic m_pulse;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next PRBS bit predicted from a history of bits (most recent at the back).
  function automatic logic predict(input logic q[$]);
    logic p;
    int   n;
    p = 1'b0;
    n = q.size();
    for (int i = 0; i < W; i++) begin
      if (TAPS[i] && (n - 1 - i) >= 0) p = p ^ q[n-1-i];
    end
    return p;
  endfunction

  function automatic logic exp_gen();
    return seq[m_gidx] ^ m_arm;
  endfunction

  task automatic m_reset();
    m_gidx = 0; m_arm = 1'b0; rxq.delete();
    m_locked = 1'b0; m_sync = 0; m_win = 0; m_werr = 0; m_cnt = 0; m_pulse = 1'b0;
  endtask

  task automatic m_step(input logic en, input logic inj, input logic clr, input logic ci);
    logic e;
    m_pulse = 1'b0;
    if (en) begin
      m_gidx++;
      if (m_arm) m_arm = 1'b0; else m_arm = inj;
      if (!m_locked) begin
        m_sync++;
        if (m_sync == W) begin m_locked = 1'b1; m_sync = 0; end
      end else begin
        e = (ci != predict(rxq));
        m_win++;
        if (e) begin
          m_werr++; m_pulse = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
        if (m_werr == LOSS) begin
          m_locked = 1'b0; m_sync = 0; m_win = 0; m_werr = 0;
        end else if (m_win == WINL) begin
          m_win = 0; m_werr = 0;
        end
      end
      rxq.push_back(ci);
      if (rxq.size() > 64) void'(rxq.pop_front());
    end else if (!m_arm) begin
      m_arm = inj;
    end
    if (clr) m_cnt = 0;
  endtask

  // One clock of the main instance; mode 0 loopback, 1 constant one.
  task automatic tick(input logic en, input logic inj, input logic clr, input int mode);
    logic ci;
    ci = (mode == 0) ? exp_gen() : 1'b1;
    Enable = en; InjErr = inj; ClrCnt = clr; ChkIn = ci;
    @(posedge Clk);
    m_step(en, inj, clr, ci);
    #1;
    check("GenOut", 64'(GenOut), 64'(exp_gen()));
    check("Locked", 64'(Locked), 64'(m_locked));
    check("ErrPulse", 64'(ErrPulse), 64'(m_pulse));
    check("ErrCnt", 64'(ErrCnt), 64'(m_cnt));
  endtask

  // One clock of the saturation instance; mode 0 random, 1 wrong bit, 2 right bit.
  task automatic stick(input logic clr, input int mode);
    logic p, ci;
    p = predict(srx);
    if (mode == 0) ci = 1'($urandom_range(1, 0));
    else if (mode == 1) ci = ~p;
    else ci = p;
    s_en = 1'b1; s_clr = clr; s_chk = ci;
    @(posedge Clk);
    srx.push_back(ci);
    if (srx.size() > 64) void'(srx.pop_front());
    #1;
  endtask

  int  first_one, lock_edge, pulses, e, guard;
  logic dropped;

  initial begin
    for (int k = 0; k < NSEQ; k++) begin
      if (k < W) seq[k] = SEED[W-1-k];
      else begin
        seq[k] = 1'b0;
        for (int i = 0; i < W; i++) if (TAPS[i]) seq[k] = seq[k] ^ seq[k-1-i];
      end
    end
    m_reset();
    ARst = 1'b1; Enable = 1'b0; InjErr = 1'b0; ChkIn = 1'b0; ClrCnt = 1'b0;
    s_en = 1'b0; s_chk = 1'b0; s_clr = 1'b0; s_inj = 1'b0;

    // Reset values
    #12;
    check("rst_GenOut", 64'(GenOut), 64'(SEED[W-1]));
    check("rst_Locked", 64'(Locked), 64'd0);
    check("rst_ErrPulse", 64'(ErrPulse), 64'd0);
    check("rst_ErrCnt", 64'(ErrCnt), 64'd0);
    check("rst_sat_ErrCnt", 64'(s_cnt), 64'd0);
    ARst = 1'b0;

    // First edge, first emitted one, lock latency
    tick(1'b1, 1'b0, 1'b0, 0);
    check("gen_state_edge1", 64'(u_dut.gen_q), 64'h3);
    first_one = -1; lock_edge = -1; e = 1;
    while (lock_edge < 0 && e < 100) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      e++;
      if (GenOut && first_one < 0) first_one = e;
      if (Locked && lock_edge < 0) lock_edge = e;
    end
    check("first_one_edge", 64'(first_one), 64'd31);
    check("lock_edge", 64'(lock_edge), 64'd32);

    // Long clean loopback
    for (int i = 0; i < 10000; i++) tick(1'b1, 1'b0, 1'b0, 0);
    check("clean_ErrCnt", 64'(ErrCnt), 64'd0);

    // Single injected error
    pulses = 0;
    tick(1'b1, 1'b1, 1'b0, 0);
    if (ErrPulse) pulses++;
    for (int i = 0; i < 60; i++) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      if (ErrPulse) pulses++;
    end
    check("inj_pulses", 64'(pulses), 64'd5);
    check("inj_ErrCnt", 64'(ErrCnt), 64'd5);
    check("inj_Locked", 64'(Locked), 64'd1);

    // Constant-one input: loss of lock after the 8th error in a fresh window
    guard = 0;
    tick(1'b1, 1'b0, 1'b0, 0);
    while (m_win != 0 && guard < 300) begin tick(1'b1, 1'b0, 1'b0, 0); guard++; end
    check("window_align", 64'(m_win), 64'd0);
    pulses = 0; dropped = 1'b0; guard = 0;
    while (!dropped && guard < 300) begin
      tick(1'b1, 1'b0, 1'b0, 1);
      guard++;
      if (ErrPulse) pulses++;
      if (!Locked) dropped = 1'b1;
    end
    check("loss_dropped", 64'(dropped), 64'd1);
    check("loss_pulses", 64'(pulses), 64'd8);
    lock_edge = -1; e = 0;
    while (lock_edge < 0 && e < 100) begin
      tick(1'b1, 1'b0, 1'b0, 0);
      e++;
      if (Locked) lock_edge = e;
    end
    check("relock_edge", 64'(lock_edge), 64'd32);

    // Build ErrCnt=7 then reset asynchronously mid-cycle
    tick(1'b1, 1'b0, 1'b1, 0);
    check("clr_ErrCnt", 64'(ErrCnt), 64'd0);
    tick(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0, 0);
    check("burst_ErrCnt", 64'(ErrCnt), 64'd5);
    tick(1'b1, 1'b1, 1'b0, 0);
    guard = 0;
    while (m_cnt != 7 && guard < 40) begin tick(1'b1, 1'b0, 1'b0, 0); guard++; end
    check("pre_rst_ErrCnt", 64'(ErrCnt), 64'd7);
    check("pre_rst_Locked", 64'(Locked), 64'd1);
    #2 ARst = 1'b1;
    #1;
    check("arst_GenOut", 64'(GenOut), 64'(SEED[W-1]));
    check("arst_Locked", 64'(Locked), 64'd0);
    check("arst_ErrPulse", 64'(ErrPulse), 64'd0);
    check("arst_ErrCnt", 64'(ErrCnt), 64'd0);
    m_reset();
    #2 ARst = 1'b0;

    // Freeze with Enable low
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0, 0);
    check("freeze_Locked", 64'(Locked), 64'd1);
    check("freeze_ErrCnt", 64'(ErrCnt), 64'd0);

    // Randomised enable, injection and clear in loopback
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(4, 0) != 0), 1'($urandom_range(63, 0) == 0),
           1'($urandom_range(99, 0) == 0), 0);
    end

    // Small counter saturation and clear priority
    Enable = 1'b0; InjErr = 1'b0; ClrCnt = 1'b0;
    for (int i = 0; i < 340; i++) stick(1'b0, 0);
    check("sat_ErrCnt", 64'(s_cnt), 64'd15);
    check("sat_Locked", 64'(s_locked), 64'd1);
    stick(1'b1, 1);
    check("sat_clr_ErrCnt", 64'(s_cnt), 64'd0);
    check("sat_clr_ErrPulse", 64'(s_pulse), 64'd1);
    stick(1'b0, 1);
    check("sat_inc_ErrCnt", 64'(s_cnt), 64'd1);
    check("sat_inc_ErrPulse", 64'(s_pulse), 64'd1);
    stick(1'b0, 2);
    check("sat_ok_ErrPulse", 64'(s_pulse), 64'd0);
    check("sat_ok_ErrCnt", 64'(s_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs.md
Name: lfsr_prbs

Overview:
- Parametrised successor to the fixed 32-bit LFSR pad-test block.
- Combines a Fibonacci PRBS generator and a self-synchronising PRBS checker in one instance.
- Width, polynomial, seed and loss-of-lock policy are configurable; the block adds an error counter, error injection and lock tracking.
- Instantiated in the user wrapper on GPIO pins for pad, loopback and board-level link testing.

Parameters:
WIDTH, 32, LFSR length in bits (4..64)
TAPS, 32'h80200003, feedback mask; bit i set means state[i] participates (default x^32+x^22+x^2+x+1)
SEED, 32'h00000001, generator reset/reload value; must be nonzero
CNT_W, 16, width of the saturating error counter
WIN, 256, loss-of-lock window length in checked cycles
LOSS_THR, 8, number of errors within one window that forces resync

Ports:
Clk  in  1  single block clock, rising edge
ARst  in  1  asynchronous reset, active-high
Enable  in  1  advances generator and checker when high; both hold when low
InjErr  in  1  single-cycle request: invert the next GenOut bit
GenOut  out  1  generator serial output
ChkIn  in  1  checker serial input, sampled on Clk when Enable=1
ClrCnt  in  1  synchronous clear of ErrCnt
Locked  out  1  checker is in LOCKED state
ErrPulse  out  1  registered; high for one cycle after a mismatched sample
ErrCnt  out  CNT_W  saturating count of mismatches since reset or clear

Behaviour:
- Reset (ARst high, asynchronous):
  - gen_state=SEED; chk_state=0; FSM=SYNC; sync count=0; window count=0; window error count=0.
  - Outputs: Locked=0, ErrPulse=0, ErrCnt=0, GenOut=SEED[WIDTH-1] (XOR any armed InjErr, cleared by reset).
- Generator:
  - GenOut = gen_state[WIDTH-1] XOR inj_armed.
  - On Enable: gen_state <= {gen_state[WIDTH-2:0], ^(gen_state & TAPS)}.
  - If gen_state is ever 0 on an enabled edge, reload SEED instead.
- Error injection:
  - InjErr=1 on an edge sets inj_armed.
  - inj_armed clears on the next enabled edge, so exactly one emitted bit is inverted.
  - Injection does not corrupt gen_state.
  - InjErr while already armed is ignored.
- Checker, enabled edges only:
  - chk_state <= {chk_state[WIDTH-2:0], ChkIn}; received bits are always shifted in (self-synchronising).
  - pred = ^(chk_state & TAPS); err = (ChkIn != pred).
- FSM SYNC:
  - Increment the sync count.
  - When the count reaches WIDTH (WIDTH samples loaded), go to LOCKED.
  - Locked rises on that edge; no errors are counted in SYNC.
- FSM LOCKED:
  - Each enabled sample increments the window count.
  - When err=1:
    - the window error count increments;
    - ErrPulse=1 on the next cycle;
    - ErrCnt increments, saturating at 2^CNT_W-1.
  - When the window error count would reach LOSS_THR: go to SYNC (Locked=0 next cycle), clear sync, window and window error counts.
  - When the window count reaches WIN-1 without loss: both window counts clear.
- ClrCnt: ErrCnt <= 0 and takes priority over a simultaneous increment. Does not affect FSM or window counters.
- Enable=0: all state, counters and Locked hold; ErrPulse deasserts.
- A single channel bit error in LOCKED with the default TAPS (4 taps) produces 1 + 4 = 5 mismatches as it propagates through the taps. The default LOSS_THR=8 therefore tolerates one isolated error per window.

Test Plan:
- Reset with SEED=1, Enable=1, sample GenOut → first 31 bits 0, then bit 1 on cycle 31; gen_state after 1 edge = 0x00000003.
- Loopback GenOut→ChkIn, Enable=1 from reset → Locked=1 after exactly 32 enabled edges; ErrCnt stays 0 over 10000 cycles.
- Locked loopback, pulse InjErr once → exactly 5 ErrPulse cycles, ErrCnt=5, Locked remains 1.
- Locked, drive ChkIn=constant 1 → Locked drops once the window error count reaches 8 (i.e. after the 8th error pulse), then re-locks 32 edges after loopback is restored.
- CNT_W=4, LOSS_THR=1000, continuous garbage input → ErrCnt saturates at 15; ClrCnt coincident with an error → ErrCnt=0.
- Assert ARst mid-stream while Locked with ErrCnt=7 → all outputs return to reset values immediately (asynchronously); Enable=0 for 50 cycles freezes GenOut, Locked and ErrCnt.
